// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: memory-port FSM encoding,
// ME-stage register bundle and data-memory address width.
package mips_pkg;

  localparam int ADDR_W_DEF = 14;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } dm_state_e;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  wreg;
    logic        rwr;
    logic        mis;
  } me_t;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/ack bus between the memory stage
// and the data memory.
interface memory_stage_if #(
  parameter int ADDR_W = 14
);

  logic              DmReq;
  logic              DmWrEn;
  logic [ADDR_W-1:0] DmAddr;
  logic [31:0]       DmWrDat;
  logic              DmAck;
  logic [31:0]       DmRdDat;

  modport master (
    output DmReq,
    output DmWrEn,
    output DmAddr,
    output DmWrDat,
    input  DmAck,
    input  DmRdDat
  );

  modport slave (
    input  DmReq,
    input  DmWrEn,
    input  DmAddr,
    input  DmWrDat,
    output DmAck,
    output DmRdDat
  );

endinterface

// File: rtl/dff.sv
// Enabled register with synchronous clear, used for
// pipeline registers.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/memory_stage_dm_port_fsm.sv
// Data-memory port sequencer: request/stall generation
// and a one-entry buffer for data completed under stall.
module dm_port_fsm
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_op_i,
  input  logic        stall_ext_i,
  input  logic        ack_i,
  input  logic [31:0] rd_dat_i,
  output logic        req_o,
  output logic        stall_o,
  output logic        advance_o,
  output logic [31:0] ld_dat_o
);

  dm_state_e   state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic        done;
  logic        req;
  logic        stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    done    = 1'b0;
    req     = 1'b0;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op_i) begin
          req = 1'b1;
          if (ack_i) begin
            done = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (ack_i) done = 1'b1;
        else       stall = 1'b1;
      end
      HOLD: begin
        if (!stall_ext_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // data completed under an external stall is parked so
    // the access is never reissued
    if (done) begin
      if (stall_ext_i) begin
        state_d = HOLD;
        hold_d  = rd_dat_i;
      end else begin
        state_d = IDLE;
      end
    end
  end

  assign req_o     = req & ~reset;
  assign stall_o   = stall;
  assign advance_o = (~stall_ext_i & ~stall & (state_q != HOLD))
                   | ((state_q == HOLD) & ~stall_ext_i);
  assign ld_dat_o  = (state_q == HOLD) ? hold_q : rd_dat_i;

endmodule

// File: rtl/memory_stage.sv
// MIPS memory stage: issues loads/stores on the data bus
// and registers the ME-stage bypass/writeback bundle.
module memory_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    Result_EX,
  input  logic [31:0]    WrDat_EX,
  input  logic [4:0]     WriteReg_EX,
  input  logic           RegWrite_EX,
  input  logic           MemToReg_EX,
  input  logic           MemWrite_EX,
  input  logic           StallExt,
  memory_stage_if.master dm,
  output logic [31:0]    ResultRdDat_ME,
  output logic [4:0]     WriteReg_ME,
  output logic           RegWrite_ME,
  output logic           Stall_ME,
  output logic           MisAlign_ME
);

  logic        mem_op;
  logic        req;
  logic        advance;
  logic [31:0] ld_dat;
  me_t         me_d, me_q;
  logic        unused_hi;

  assign mem_op = MemToReg_EX | MemWrite_EX;

  dm_port_fsm u_fsm (
    .clk        (clk),
    .reset      (reset),
    .mem_op_i   (mem_op),
    .stall_ext_i(StallExt),
    .ack_i      (dm.DmAck),
    .rd_dat_i   (dm.DmRdDat),
    .req_o      (req),
    .stall_o    (Stall_ME),
    .advance_o  (advance),
    .ld_dat_o   (ld_dat)
  );

  assign dm.DmReq   = req;
  assign dm.DmWrEn  = MemWrite_EX;
  assign dm.DmAddr  = Result_EX[ADDR_W+1:2];
  assign dm.DmWrDat = WrDat_EX;

  assign unused_hi = ^Result_EX[31:ADDR_W+2];

  always_comb begin
    me_d      = '0;
    me_d.res  = MemToReg_EX ? ld_dat : Result_EX;
    me_d.wreg = WriteReg_EX;
    me_d.rwr  = RegWrite_EX;
    me_d.mis  = mem_op & (|Result_EX[1:0]);
  end

  dff #(.W($bits(me_t))) u_me (
    .clk(clk),
    .clr(reset),
    .en (advance),
    .d  (me_d),
    .q  (me_q)
  );

  assign ResultRdDat_ME = me_q.res;
  assign WriteReg_ME    = me_q.wreg;
  assign RegWrite_ME    = me_q.rwr;
  assign MisAlign_ME    = me_q.mis;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass, loads,
// stores with waits, hold under stall, reset, misalign.
module tb_memory_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Result_EX;
  logic [31:0] WrDat_EX;
  logic [4:0]  WriteReg_EX;
  logic        RegWrite_EX;
  logic        MemToReg_EX;
  logic        MemWrite_EX;
  logic        StallExt;
  logic [31:0] ResultRdDat_ME;
  logic [4:0]  WriteReg_ME;
  logic        RegWrite_ME;
  logic        Stall_ME;
  logic        MisAlign_ME;

  int errors = 0;
  int checks = 0;

  memory_stage_if #(.ADDR_W(14)) dm ();

  memory_stage #(.ADDR_W(14)) dut (
    .clk           (clk),
    .reset         (reset),
    .Result_EX     (Result_EX),
    .WrDat_EX      (WrDat_EX),
    .WriteReg_EX   (WriteReg_EX),
    .RegWrite_EX   (RegWrite_EX),
    .MemToReg_EX   (MemToReg_EX),
    .MemWrite_EX   (MemWrite_EX),
    .StallExt      (StallExt),
    .dm            (dm.master),
    .ResultRdDat_ME(ResultRdDat_ME),
    .WriteReg_ME   (WriteReg_ME),
    .RegWrite_ME   (RegWrite_ME),
    .Stall_ME      (Stall_ME),
    .MisAlign_ME   (MisAlign_ME)
  );

  always #5 clk = ~clk;

  task automatic clr_in();
    Result_EX   = '0;
    WrDat_EX    = '0;
    WriteReg_EX = '0;
    RegWrite_EX = 1'b0;
    MemToReg_EX = 1'b0;
    MemWrite_EX = 1'b0;
    StallExt    = 1'b0;
    dm.DmAck    = 1'b0;
    dm.DmRdDat  = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clr_in();
    reset = 1'b1;
    MemToReg_EX = 1'b1;
    #1;
    checks++;
    if (dm.DmReq !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got=%b exp=0", dm.DmReq);
    end
    tick();
    checks++;
    if ({ResultRdDat_ME, WriteReg_ME, RegWrite_ME, MisAlign_ME}
        !== 39'd0) begin
      errors++;
      $display("FAIL rst_me got=%h/%0d/%b/%b exp=0",
               ResultRdDat_ME, WriteReg_ME, RegWrite_ME,
               MisAlign_ME);
    end
    @(negedge clk);
    reset = 1'b0;
    clr_in();
  endtask

  task automatic test_alu();
    @(negedge clk);
    clr_in();
    Result_EX   = 32'h1234;
    WriteReg_EX = 5'd5;
    RegWrite_EX = 1'b1;
    dm.DmAck    = 1'b1;
    #1;
    checks++;
    if ({dm.DmReq, Stall_ME} !== 2'b00) begin
      errors++;
      $display("FAIL alu_req got=%b%b exp=00",
               dm.DmReq, Stall_ME);
    end
    tick();
    checks++;
    if (ResultRdDat_ME !== 32'h1234 || WriteReg_ME !== 5'd5
        || RegWrite_ME !== 1'b1) begin
      errors++;
      $display("FAIL alu_me got=%h/%0d/%b exp=1234/5/1",
               ResultRdDat_ME, WriteReg_ME, RegWrite_ME);
    end
  endtask

  task automatic test_zero_wait_load();
    @(negedge clk);
    clr_in();
    Result_EX   = 32'h40;
    WriteReg_EX = 5'd7;
    RegWrite_EX = 1'b1;
    MemToReg_EX = 1'b1;
    dm.DmAck    = 1'b1;
    dm.DmRdDat  = 32'hDEADBEEF;
    #1;
    checks++;
    if (dm.DmAddr !== 14'h10 || dm.DmReq !== 1'b1
        || Stall_ME !== 1'b0 || dm.DmWrEn !== 1'b0) begin
      errors++;
      $display("FAIL zw_bus got=%h/%b/%b exp=010/1/0",
               dm.DmAddr, dm.DmReq, Stall_ME);
    end
    tick();
    checks++;
    if (ResultRdDat_ME !== 32'hDEADBEEF || WriteReg_ME !== 5'd7
        || MisAlign_ME !== 1'b0) begin
      errors++;
      $display("FAIL zw_me got=%h/%0d/%b exp=deadbeef/7/0",
               ResultRdDat_ME, WriteReg_ME, MisAlign_ME);
    end
  endtask

  task automatic test_store_wait();
    int stalls;
    int bad;
    stalls = 0;
    bad = 0;
    @(negedge clk);
    clr_in();
    Result_EX   = 32'h100;
    WrDat_EX    = 32'hA5A5A5A5;
    WriteReg_EX = 5'd3;
    MemWrite_EX = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (Stall_ME === 1'b1) stalls++;
      if (dm.DmReq !== 1'b1 || dm.DmWrEn !== 1'b1
          || dm.DmAddr !== 14'h40
          || dm.DmWrDat !== 32'hA5A5A5A5) bad++;
      @(posedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL st_bus got=%0d bad cycles exp=0", bad);
    end
    checks++;
    if (ResultRdDat_ME !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL st_hold got=%h exp=deadbeef",
               ResultRdDat_ME);
    end
    @(negedge clk);
    dm.DmAck = 1'b1;
    #1;
    if (Stall_ME === 1'b1) stalls++;
    checks++;
    if (dm.DmReq !== 1'b1) begin
      errors++;
      $display("FAIL st_ackreq got=%b exp=1", dm.DmReq);
    end
    checks++;
    if (stalls != 3) begin
      errors++;
      $display("FAIL st_stalls got=%0d exp=3", stalls);
    end
    tick();
    checks++;
    if (RegWrite_ME !== 1'b0 || ResultRdDat_ME !== 32'h100) begin
      errors++;
      $display("FAIL st_me got=%b/%h exp=0/100",
               RegWrite_ME, ResultRdDat_ME);
    end
  endtask

  task automatic test_hold();
    int reqs;
    reqs = 0;
    @(negedge clk);
    clr_in();
    Result_EX   = 32'h80;
    WriteReg_EX = 5'd9;
    RegWrite_EX = 1'b1;
    MemToReg_EX = 1'b1;
    StallExt    = 1'b1;
    tick();
    @(negedge clk);
    dm.DmAck   = 1'b1;
    dm.DmRdDat = 32'hCAFEF00D;
    #1;
    checks++;
    if (Stall_ME !== 1'b0 || dm.DmReq !== 1'b1) begin
      errors++;
      $display("FAIL hd_ack got=%b/%b exp=0/1",
               Stall_ME, dm.DmReq);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      dm.DmAck   = 1'b1;
      dm.DmRdDat = 32'h0BAD0BAD;
      #1;
      if (dm.DmReq !== 1'b0 || Stall_ME !== 1'b0) reqs++;
    end
    checks++;
    if (reqs != 0) begin
      errors++;
      $display("FAIL hd_noreq got=%0d exp=0", reqs);
    end
    checks++;
    if (ResultRdDat_ME !== 32'h100) begin
      errors++;
      $display("FAIL hd_keep got=%h exp=100", ResultRdDat_ME);
    end
    @(negedge clk);
    StallExt = 1'b0;
    dm.DmAck = 1'b0;
    #1;
    checks++;
    if (dm.DmReq !== 1'b0) begin
      errors++;
      $display("FAIL hd_exitreq got=%b exp=0", dm.DmReq);
    end
    tick();
    checks++;
    if (ResultRdDat_ME !== 32'hCAFEF00D || WriteReg_ME !== 5'd9) begin
      errors++;
      $display("FAIL hd_me got=%h/%0d exp=cafef00d/9",
               ResultRdDat_ME, WriteReg_ME);
    end
  endtask

  task automatic test_reset_wait();
    @(negedge clk);
    clr_in();
    Result_EX   = 32'h60;
    WriteReg_EX = 5'd4;
    RegWrite_EX = 1'b1;
    MemToReg_EX = 1'b1;
    tick();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (dm.DmReq !== 1'b0) begin
      errors++;
      $display("FAIL rw_req got=%b exp=0", dm.DmReq);
    end
    tick();
    checks++;
    if ({ResultRdDat_ME, WriteReg_ME, RegWrite_ME, MisAlign_ME}
        !== 39'd0) begin
      errors++;
      $display("FAIL rw_me got=%h/%0d/%b exp=0",
               ResultRdDat_ME, WriteReg_ME, RegWrite_ME);
    end
    @(negedge clk);
    reset       = 1'b0;
    Result_EX   = 32'h20;
    WriteReg_EX = 5'd6;
    dm.DmAck    = 1'b1;
    dm.DmRdDat  = 32'h11223344;
    #1;
    checks++;
    if (dm.DmReq !== 1'b1 || Stall_ME !== 1'b0
        || dm.DmAddr !== 14'h8) begin
      errors++;
      $display("FAIL rw_bus got=%b/%b/%h exp=1/0/008",
               dm.DmReq, Stall_ME, dm.DmAddr);
    end
    tick();
    checks++;
    if (ResultRdDat_ME !== 32'h11223344 || WriteReg_ME !== 5'd6) begin
      errors++;
      $display("FAIL rw_me2 got=%h/%0d exp=11223344/6",
               ResultRdDat_ME, WriteReg_ME);
    end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    clr_in();
    Result_EX   = 32'h43;
    WriteReg_EX = 5'd2;
    RegWrite_EX = 1'b1;
    MemToReg_EX = 1'b1;
    dm.DmAck    = 1'b1;
    dm.DmRdDat  = 32'h55;
    #1;
    checks++;
    if (dm.DmAddr !== 14'h10) begin
      errors++;
      $display("FAIL ma_addr got=%h exp=010", dm.DmAddr);
    end
    tick();
    checks++;
    if (MisAlign_ME !== 1'b1 || ResultRdDat_ME !== 32'h55) begin
      errors++;
      $display("FAIL ma_set got=%b/%h exp=1/55",
               MisAlign_ME, ResultRdDat_ME);
    end
    @(negedge clk);
    clr_in();
    Result_EX   = 32'h7;
    RegWrite_EX = 1'b1;
    tick();
    checks++;
    if (MisAlign_ME !== 1'b0 || ResultRdDat_ME !== 32'h7) begin
      errors++;
      $display("FAIL ma_clr got=%b/%h exp=0/7",
               MisAlign_ME, ResultRdDat_ME);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    clr_in();
    Result_EX   = 32'h200;
    WriteReg_EX = 5'd10;
    RegWrite_EX = 1'b1;
    MemToReg_EX = 1'b1;
    tick();
    @(negedge clk);
    dm.DmAck   = 1'b1;
    dm.DmRdDat = 32'h1;
    tick();
    checks++;
    if (ResultRdDat_ME !== 32'h1 || WriteReg_ME !== 5'd10) begin
      errors++;
      $display("FAIL bb_first got=%h/%0d exp=1/10",
               ResultRdDat_ME, WriteReg_ME);
    end
    @(negedge clk);
    Result_EX   = 32'h204;
    WriteReg_EX = 5'd11;
    dm.DmAck    = 1'b0;
    #1;
    checks++;
    if (dm.DmReq !== 1'b1 || Stall_ME !== 1'b1
        || dm.DmAddr !== 14'h81) begin
      errors++;
      $display("FAIL bb_issue got=%b/%b/%h exp=1/1/081",
               dm.DmReq, Stall_ME, dm.DmAddr);
    end
    tick();
    @(negedge clk);
    dm.DmAck   = 1'b1;
    dm.DmRdDat = 32'h2;
    tick();
    checks++;
    if (ResultRdDat_ME !== 32'h2 || WriteReg_ME !== 5'd11) begin
      errors++;
      $display("FAIL bb_second got=%h/%0d exp=2/11",
               ResultRdDat_ME, WriteReg_ME);
    end
    @(negedge clk);
    clr_in();
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    test_reset();
    test_alu();
    test_zero_wait_load();
    test_store_wait();
    test_hold();
    test_reset_wait();
    test_misalign();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
